// File: rtl/mb_search_sched.sv
// mb_search_sched: steps a frame's macroblocks through INIT/RUN/FLUSH/REPORT and tracks the best SAD candidate.
module mb_search_sched #(
  parameter int SAD_W        = 16,
  parameter int INIT_CYCLES  = 73,
  parameter int ROW_CYCLES   = 24,
  parameter int SEARCH_ROWS  = 16,
  parameter int CAND_X       = 16,
  parameter int FLUSH_CYCLES = 8,
  parameter int MB_COLS      = 22,
  parameter int MB_ROWS      = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ctr_rst_n,
  output logic             en_init,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad_in,
  output logic             mv_valid,
  input  logic             mv_ready,
  output logic [4:0]       mv_x,
  output logic [4:0]       mv_y,
  output logic [SAD_W-1:0] min_sad,
  output logic [4:0]       mb_x,
  output logic [4:0]       mb_y,
  output logic             err
);
  localparam int RUN_CYCLES = ROW_CYCLES * SEARCH_ROWS;
  localparam int N_CAND = CAND_X * SEARCH_ROWS;
  localparam int CNT_W = $clog2(N_CAND + 1);
  typedef enum logic [2:0] {IDLE, INIT, RUN, FLUSH, REPORT} state_t;
  state_t state_q, state_d;
  logic [15:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d, mv_x_q, mv_x_d, mv_y_q, mv_y_d;
  logic [4:0] mb_x_q, mb_x_d, mb_y_q, mb_y_d;
  logic [SAD_W-1:0] min_sad_q, min_sad_d;
  logic err_q, err_d, done_q, done_d;
  logic capture, take, cand_x_wrap, mb_x_wrap, last_mb;
  assign capture = (state_q == RUN || state_q == FLUSH) && sad_valid;
  assign take = capture && cnt_q < CNT_W'(N_CAND);
  assign cand_x_wrap = cand_x_q == 5'(CAND_X - 1);
  assign mb_x_wrap = mb_x_q == 5'(MB_COLS - 1);
  assign last_mb = mb_x_wrap && mb_y_q == 5'(MB_ROWS - 1);
  always_comb begin
    state_d = state_q;
    cyc_d = cyc_q + 16'd1;
    cnt_d = cnt_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    mv_x_d = mv_x_q;
    mv_y_d = mv_y_q;
    mb_x_d = mb_x_q;
    mb_y_d = mb_y_q;
    min_sad_d = min_sad_q;
    err_d = err_q;
    done_d = 1'b0;
    if (take) begin
      cnt_d = cnt_q + 1'b1;
      cand_x_d = cand_x_wrap ? 5'd0 : cand_x_q + 5'd1;
      cand_y_d = cand_x_wrap ? cand_y_q + 5'd1 : cand_y_q;
      if (sad_in < min_sad_q) begin
        min_sad_d = sad_in;
        mv_x_d = cand_x_q;
        mv_y_d = cand_y_q;
      end
    end
    if (capture && !take) err_d = 1'b1;
    case (state_q)
      IDLE: if (start) begin
        state_d = INIT;
        mb_x_d = 5'd0;
        mb_y_d = 5'd0;
        err_d = 1'b0;
      end
      INIT: if (cyc_q == 16'(INIT_CYCLES - 1)) state_d = RUN;
      RUN: if (cyc_q == 16'(RUN_CYCLES - 1)) state_d = FLUSH;
      FLUSH: if (cyc_q == 16'(FLUSH_CYCLES - 1)) begin
        state_d = REPORT;
        if (cnt_d < CNT_W'(N_CAND)) err_d = 1'b1;
      end
      REPORT: if (mv_ready) begin
        state_d = last_mb ? IDLE : INIT;
        done_d = last_mb;
        mb_x_d = mb_x_wrap ? 5'd0 : mb_x_q + 5'd1;
        mb_y_d = last_mb ? 5'd0 : mb_x_wrap ? mb_y_q + 5'd1 : mb_y_q;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cyc_d = 16'd0;
    // every macroblock search starts from a clean best-candidate record
    if (state_d == INIT && state_q != INIT) begin
      min_sad_d = '1;
      cand_x_d = 5'd0;
      cand_y_d = 5'd0;
      mv_x_d = 5'd0;
      mv_y_d = 5'd0;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q <= 16'd0;
      cnt_q <= '0;
      cand_x_q <= 5'd0;
      cand_y_q <= 5'd0;
      mv_x_q <= 5'd0;
      mv_y_q <= 5'd0;
      mb_x_q <= 5'd0;
      mb_y_q <= 5'd0;
      min_sad_q <= '1;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      cnt_q <= cnt_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      mv_x_q <= mv_x_d;
      mv_y_q <= mv_y_d;
      mb_x_q <= mb_x_d;
      mb_y_q <= mb_y_d;
      min_sad_q <= min_sad_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign ctr_rst_n = state_q == INIT || state_q == RUN || state_q == FLUSH;
  assign en_init = state_q == INIT;
  assign mv_valid = state_q == REPORT;
  assign mv_x = mv_x_q;
  assign mv_y = mv_y_q;
  assign min_sad = min_sad_q;
  assign mb_x = mb_x_q;
  assign mb_y = mb_y_q;
  assign err = err_q;
endmodule

// File: tb/tb_mb_search_sched.sv
// tb_mb_search_sched: random and directed macroblock searches on a 2x2-macroblock frame, checked against a reference model.
module tb_mb_search_sched;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sad_valid = 1'b0, mv_ready = 1'b0;
  logic [15:0] sad_in = 16'd0;
  logic busy, done, ctr_rst_n, en_init, mv_valid, err;
  logic [4:0] mv_x, mv_y, mb_x, mb_y;
  logic [15:0] min_sad;
  int checks = 0, fails = 0, cyc = 0, done_cnt = 0;
  int exp_mbx = 0, exp_mby = 0;
  logic exp_err = 1'b0;

  mb_search_sched #(.MB_COLS(2), .MB_ROWS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ctr_rst_n(ctr_rst_n), .en_init(en_init), .sad_valid(sad_valid), .sad_in(sad_in),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_x(mv_x), .mv_y(mv_y),
    .min_sad(min_sad), .mb_x(mb_x), .mb_y(mb_y), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    checks++; if (err !== exp_err) begin fails++; $display("FAIL err_before_start got %0b want %0b", err, exp_err); end
    start = 1'b1;
    step;
    start = 1'b0;
    exp_err = 1'b0; exp_mbx = 0; exp_mby = 0;
    checks++; if ({busy, en_init, err, mb_x, mb_y} !== {3'b110, 10'd0})
      begin fails++; $display("FAIL start_state got %b want %b", {busy, en_init, err, mb_x, mb_y}, {3'b110, 10'd0}); end
  endtask

  // kind: 0 random with ties/all-ones, 1 descending with forced minimum, 2 all equal, 3 high values plus trailing zero
  task automatic run_mb(input int n, input int kind, input int hold, input bit pulse_start, input bit abort);
    logic [15:0] vals[$];
    logic [15:0] best, v;
    logic [36:0] snap;
    int bx, by, k, t0;
    bit last;
    vals = {};
    for (int i = 0; i < n; i++) begin
      case (kind)
        1: v = (i == 37) ? 16'd5 : 16'(1000 - i);
        2: v = 16'd100;
        3: v = (i == 256) ? 16'd0 : 16'(500 + $urandom_range(0, 400));
        default: v = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 300));
      endcase
      vals.push_back(v);
    end
    best = 16'hFFFF; bx = 0; by = 0;
    for (int i = 0; i < n && i < 256; i++)
      if (vals[i] < best) begin best = vals[i]; bx = i % 16; by = i / 16; end
    if (n != 256) exp_err = 1'b1;
    k = 0;
    while (!en_init && k < 10) begin k++; step; end
    k = 0;
    while (en_init && k < 200) begin sad_valid = 1'b1; sad_in = 16'd0; k++; step; end
    sad_valid = 1'b0;
    checks++; if (k !== 73) begin fails++; $display("FAIL init_len got %0d want 73", k); end
    checks++; if ({ctr_rst_n, en_init} !== 2'b10) begin fails++; $display("FAIL run_ctrl got %b want 10", {ctr_rst_n, en_init}); end
    t0 = cyc;
    foreach (vals[i]) begin
      if (i < 100 && $urandom_range(0, 3) == 0) begin sad_valid = 1'b0; step; end
      sad_valid = 1'b1; sad_in = vals[i];
      if (pulse_start && i == 50) start = 1'b1;
      step;
      start = 1'b0;
      if (abort && i == 9) begin
        sad_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if ({busy, done, ctr_rst_n, en_init, mv_valid, err, mv_x, mv_y, mb_x, mb_y, min_sad} !== {6'b0, 20'd0, 16'hFFFF})
          begin fails++; $display("FAIL abort_reset got %h want %h", {busy, done, ctr_rst_n, en_init, mv_valid, err, mv_x, mv_y, mb_x, mb_y, min_sad}, {6'b0, 20'd0, 16'hFFFF}); end
        step;
        rst = 1'b0;
        repeat (5) step;
        checks++; if ({busy, done, ctr_rst_n, en_init, mv_valid} !== 5'b0)
          begin fails++; $display("FAIL abort_no_resume got %b want 00000", {busy, done, ctr_rst_n, en_init, mv_valid}); end
        exp_err = 1'b0; exp_mbx = 0; exp_mby = 0;
        return;
      end
    end
    sad_valid = 1'b0;
    k = 0;
    while (!mv_valid && k < 1000) begin k++; step; end
    checks++; if (mv_valid !== 1'b1) begin fails++; $display("FAIL report_timeout got %b want 1", mv_valid); end
    checks++; if (cyc - t0 !== 392) begin fails++; $display("FAIL run_flush_len got %0d want 392", cyc - t0); end
    checks++; if ({mv_x, mv_y, min_sad} !== {5'(bx), 5'(by), best})
      begin fails++; $display("FAIL best_cand got x=%0d y=%0d sad=%0d want x=%0d y=%0d sad=%0d", mv_x, mv_y, min_sad, bx, by, best); end
    checks++; if ({mb_x, mb_y, err} !== {5'(exp_mbx), 5'(exp_mby), exp_err})
      begin fails++; $display("FAIL report_mb_err got mb=(%0d,%0d) err=%0b want mb=(%0d,%0d) err=%0b", mb_x, mb_y, err, exp_mbx, exp_mby, exp_err); end
    checks++; if ({ctr_rst_n, en_init, busy} !== 3'b001) begin fails++; $display("FAIL report_ctrl got %b want 001", {ctr_rst_n, en_init, busy}); end
    snap = {mv_x, mv_y, min_sad, mb_x, mb_y, err};
    for (int i = 0; i < hold; i++) begin
      sad_valid = 1'b1; sad_in = 16'd0;
      step;
      checks++; if ({mv_valid, en_init, mv_x, mv_y, min_sad, mb_x, mb_y, err} !== {2'b10, snap})
        begin fails++; $display("FAIL hold_stable cycle %0d got %h want %h", i, {mv_valid, en_init, mv_x, mv_y, min_sad, mb_x, mb_y, err}, {2'b10, snap}); end
    end
    sad_valid = 1'b0;
    mv_ready = 1'b1;
    step;
    mv_ready = 1'b0;
    last = exp_mbx == 1 && exp_mby == 1;
    if (exp_mbx == 1) begin exp_mbx = 0; exp_mby = last ? 0 : exp_mby + 1; end else exp_mbx++;
    if (last) begin
      checks++; if ({mv_valid, done, busy, en_init} !== 4'b0100) begin fails++; $display("FAIL frame_end got %b want 0100", {mv_valid, done, busy, en_init}); end
      step;
      checks++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL done_pulse got %b want 00", {done, busy}); end
    end else begin
      checks++; if ({mv_valid, done, busy, en_init, mb_x, mb_y, min_sad, mv_x, mv_y} !== {4'b0011, 5'(exp_mbx), 5'(exp_mby), 16'hFFFF, 10'd0})
        begin fails++; $display("FAIL next_mb got %h want %h", {mv_valid, done, busy, en_init, mb_x, mb_y, min_sad, mv_x, mv_y}, {4'b0011, 5'(exp_mbx), 5'(exp_mby), 16'hFFFF, 10'd0}); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step;
    checks++; if ({busy, done, ctr_rst_n, en_init, mv_valid, err, mv_x, mv_y, mb_x, mb_y, min_sad} !== {6'b0, 20'd0, 16'hFFFF})
      begin fails++; $display("FAIL reset_values got %h want %h", {busy, done, ctr_rst_n, en_init, mv_valid, err, mv_x, mv_y, mb_x, mb_y, min_sad}, {6'b0, 20'd0, 16'hFFFF}); end
    rst = 1'b0;
    repeat (3) step;
    checks++; if ({busy, ctr_rst_n, en_init, mv_valid} !== 4'b0) begin fails++; $display("FAIL idle_hold got %b want 0000", {busy, ctr_rst_n, en_init, mv_valid}); end
  endtask

  task automatic test_min_tracking;
    do_start;
    run_mb(256, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ties;
    run_mb(256, 2, 0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure;
    run_mb(256, 0, 50, 1'b0, 1'b0);
  endtask

  task automatic test_full_frame;
    run_mb(256, 0, 3, 1'b0, 1'b0);
    repeat (5) step;
    checks++; if ({busy, en_init, ctr_rst_n, done_cnt} !== {3'b000, 32'd1})
      begin fails++; $display("FAIL frame_idle got busy=%0b en_init=%0b ctr_rst_n=%0b dones=%0d want 0 0 0 1", busy, en_init, ctr_rst_n, done_cnt); end
  endtask

  task automatic test_count_errors;
    do_start;
    run_mb(255, 0, 0, 1'b0, 1'b0);
    run_mb(256, 0, 0, 1'b0, 1'b0);
    run_mb(256, 0, 0, 1'b0, 1'b0);
    run_mb(256, 0, 0, 1'b0, 1'b0);
    do_start;
    run_mb(256, 0, 0, 1'b0, 1'b0);
    run_mb(257, 3, 0, 1'b0, 1'b0);
    run_mb(256, 0, 2, 1'b0, 1'b0);
    run_mb(256, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort;
    do_start;
    run_mb(256, 0, 0, 1'b0, 1'b0);
    run_mb(10, 0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset;
    test_min_tracking;
    test_ties;
    test_backpressure;
    test_full_frame;
    test_count_errors;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
